// File: rtl/sargantana_icache_refill.sv
// Instruction-cache refill engine: takes a miss, picks a victim way, fetches
// the line from memory as N_BEATS beats and issues a single write strobe to
// the tag/data arrays. A kill (pipeline flush) abandons the fill without writing.
module sargantana_icache_refill #(
  parameter int ICACHE_N_WAY = 4,
  parameter int TAG_WIDHT    = 20,
  parameter int IDX_WIDHT    = 6,
  parameter int WAY_WIDHT    = 512,
  parameter int BEAT_WIDHT   = 128
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           miss_valid_i,
  output logic                           miss_ready_o,
  input  logic [TAG_WIDHT-1:0]           miss_tag_i,
  input  logic [IDX_WIDHT-1:0]           miss_idx_i,
  input  logic [ICACHE_N_WAY-1:0]        way_valid_bits_i,
  input  logic                           kill_i,
  output logic                           mem_req_valid_o,
  input  logic                           mem_req_ready_i,
  output logic [TAG_WIDHT+IDX_WIDHT-1:0] mem_req_addr_o,
  input  logic                           mem_rsp_valid_i,
  input  logic [BEAT_WIDHT-1:0]          mem_rsp_data_i,
  output logic                           wr_en_o,
  output logic [ICACHE_N_WAY-1:0]        wr_way_o,
  output logic [IDX_WIDHT-1:0]           wr_idx_o,
  output logic [TAG_WIDHT-1:0]           wr_tag_o,
  output logic [WAY_WIDHT-1:0]           wr_data_o,
  output logic                           busy_o
);

  localparam int N_BEATS = WAY_WIDHT / BEAT_WIDHT;
  localparam int CNT_W   = $clog2(N_BEATS);
  localparam int RR_W    = $clog2(ICACHE_N_WAY);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RECV  = 2'd2,
    WRITE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [RR_W-1:0]         rr_q, rr_d;
  logic                    killed_q, killed_d;
  logic                    from_rr_q, from_rr_d;
  logic [TAG_WIDHT-1:0]    tag_q, tag_d;
  logic [IDX_WIDHT-1:0]    idx_q, idx_d;
  logic [ICACHE_N_WAY-1:0] way_q, way_d;
  logic [WAY_WIDHT-1:0]    line_q, line_d;

  logic                    free_found;
  logic [RR_W-1:0]         free_idx;
  logic [RR_W-1:0]         victim_idx;
  logic                    killed_set;

  // Next-state logic: victim choice, request handshake, beat assembly, write commit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    killed_d   = killed_q;
    from_rr_d  = from_rr_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    way_d      = way_q;
    line_d     = line_q;
    killed_set = killed_q | kill_i;

    // Scan downward so the lowest-index invalid way is the one that sticks.
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ICACHE_N_WAY - 1; i >= 0; i--) begin
      if (!way_valid_bits_i[i]) begin
        free_found = 1'b1;
        free_idx   = RR_W'(i);
      end
    end
    victim_idx = free_found ? free_idx : rr_q;

    case (state_q)
      IDLE: begin
        if (miss_valid_i && !kill_i) begin
          tag_d             = miss_tag_i;
          idx_d             = miss_idx_i;
          way_d             = '0;
          way_d[victim_idx] = 1'b1;
          from_rr_d         = !free_found;
          killed_d          = 1'b0;
          cnt_d             = '0;
          state_d           = REQ;
        end
      end
      REQ: begin
        // A kill in the acceptance cycle still counts as accepted: the
        // response must be drained, so it becomes a kill seen in RECV.
        if (mem_req_ready_i) begin
          cnt_d    = '0;
          killed_d = kill_i;
          state_d  = RECV;
        end else if (kill_i) begin
          state_d = IDLE;
        end
      end
      RECV: begin
        killed_d = killed_set;
        if (mem_rsp_valid_i) begin
          line_d[BEAT_WIDHT*cnt_q +: BEAT_WIDHT] = mem_rsp_data_i;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = killed_set ? IDLE : WRITE;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
        // Only a committed pointer-chosen eviction advances the pointer.
        if (!kill_i && from_rr_q) begin
          rr_d = rr_q + RR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rr_q      <= '0;
      killed_q  <= 1'b0;
      from_rr_q <= 1'b0;
      tag_q     <= '0;
      idx_q     <= '0;
      way_q     <= '0;
      line_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      killed_q  <= killed_d;
      from_rr_q <= from_rr_d;
      tag_q     <= tag_d;
      idx_q     <= idx_d;
      way_q     <= way_d;
      line_q    <= line_d;
    end
  end

  assign miss_ready_o    = (state_q == IDLE);
  assign busy_o          = (state_q != IDLE);
  assign mem_req_valid_o = (state_q == REQ);
  assign mem_req_addr_o  = {tag_q, idx_q};
  // A late kill during WRITE must still block the array update.
  assign wr_en_o         = (state_q == WRITE) && !kill_i;
  assign wr_way_o        = way_q;
  assign wr_idx_o        = idx_q;
  assign wr_tag_o        = tag_q;
  assign wr_data_o       = line_q;

endmodule

// File: tb/tb_sargantana_icache_refill.sv
// Directed bench for the icache refill engine.
module tb_sargantana_icache_refill;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         miss_valid_i;
  logic         miss_ready_o;
  logic [19:0]  miss_tag_i;
  logic [5:0]   miss_idx_i;
  logic [3:0]   way_valid_bits_i;
  logic         kill_i;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic [25:0]  mem_req_addr_o;
  logic         mem_rsp_valid_i;
  logic [127:0] mem_rsp_data_i;
  logic         wr_en_o;
  logic [3:0]   wr_way_o;
  logic [5:0]   wr_idx_o;
  logic [19:0]  wr_tag_o;
  logic [511:0] wr_data_o;
  logic         busy_o;

  int n_vec = 0;
  int n_err = 0;

  sargantana_icache_refill dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
    .miss_tag_i(miss_tag_i), .miss_idx_i(miss_idx_i),
    .way_valid_bits_i(way_valid_bits_i), .kill_i(kill_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .wr_en_o(wr_en_o), .wr_way_o(wr_way_o), .wr_idx_o(wr_idx_o),
    .wr_tag_o(wr_tag_o), .wr_data_o(wr_data_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] beat(input logic [31:0] seed, input int k);
    return {seed + 32'(k), ~seed, 32'hC0DE_0000 | 32'(k), seed ^ 32'(k * 7)};
  endfunction

  // One fill with immediate request acceptance and back-to-back beats.
  task automatic fill(input logic [19:0] tag, input logic [5:0] idx, input logic [3:0] vbits,
                      input logic [31:0] seed, input logic [3:0] exp_way, input bit kill_wr);
    logic [511:0] exp_line;
    miss_valid_i = 1'b1; miss_tag_i = tag; miss_idx_i = idx; way_valid_bits_i = vbits;
    tick();
    miss_valid_i = 1'b0;
    chk("req_valid", mem_req_valid_o, 512'd1);
    chk("req_addr", mem_req_addr_o, {486'd0, tag, idx});
    chk("busy_req", busy_o, 512'd1);
    chk("miss_ready_req", miss_ready_o, 512'd0);
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    chk("req_dropped", mem_req_valid_o, 512'd0);
    for (int k = 0; k < 4; k++) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = beat(seed, k);
      exp_line[k*128 +: 128] = beat(seed, k);
      tick();
      if (k < 3) chk("wr_en_early", wr_en_o, 512'd0);
    end
    mem_rsp_valid_i = 1'b0;
    if (kill_wr) begin
      kill_i = 1'b1;
      #1;
      chk("wr_en_killed", wr_en_o, 512'd0);
      tick();
      kill_i = 1'b0;
    end else begin
      chk("wr_en", wr_en_o, 512'd1);
      chk("wr_way", wr_way_o, {508'd0, exp_way});
      chk("wr_tag", wr_tag_o, {492'd0, tag});
      chk("wr_idx", wr_idx_o, {506'd0, idx});
      chk("wr_data", wr_data_o, exp_line);
      tick();
    end
    chk("wr_en_single", wr_en_o, 512'd0);
    chk("busy_done", busy_o, 512'd0);
    chk("wr_way_held", wr_way_o, {508'd0, exp_way});
  endtask

  initial begin
    rst_i = 1'b1; miss_valid_i = 1'b0; miss_tag_i = 20'd0; miss_idx_i = 6'd0;
    way_valid_bits_i = 4'd0; kill_i = 1'b0; mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0; mem_rsp_data_i = 128'd0;

    // Reset state
    tick(); tick();
    chk("rst_busy", busy_o, 512'd0);
    chk("rst_req_valid", mem_req_valid_o, 512'd0);
    chk("rst_wr_en", wr_en_o, 512'd0);
    chk("rst_wr_way", wr_way_o, 512'd0);
    chk("rst_wr_data", wr_data_o, 512'd0);
    rst_i = 1'b0;
    tick();
    chk("rst_miss_ready", miss_ready_o, 512'd1);

    // Basic fill: first invalid way (bit 2) is the victim
    fill(20'h12345, 6'd5, 4'b1011, 32'h1111_0000, 4'b0100, 1'b0);

    // All ways valid: round-robin walks 0,1,2
    fill(20'h00A01, 6'd1, 4'b1111, 32'h2222_0000, 4'b0001, 1'b0);
    fill(20'h00A02, 6'd2, 4'b1111, 32'h3333_0000, 4'b0010, 1'b0);
    fill(20'h00A03, 6'd3, 4'b1111, 32'h4444_0000, 4'b0100, 1'b0);

    // Kill after beat 1: beats still drained, no write, pointer unchanged
    miss_valid_i = 1'b1; miss_tag_i = 20'h0BEEF; miss_idx_i = 6'd9; way_valid_bits_i = 4'b1111;
    tick();
    miss_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = beat(32'h5555_0000, k);
      kill_i = (k == 2);
      tick();
      chk("kill_no_wr", wr_en_o, 512'd0);
      if (k < 3) chk("kill_draining", busy_o, 512'd1);
    end
    mem_rsp_valid_i = 1'b0; kill_i = 1'b0;
    chk("kill_idle", miss_ready_o, 512'd1);
    tick();
    chk("kill_no_wr_after", wr_en_o, 512'd0);
    fill(20'h0C0DE, 6'd10, 4'b1111, 32'h6666_0000, 4'b1000, 1'b0);

    // Kill in WRITE: strobe suppressed, pointer (now 0) unchanged
    fill(20'h0D00D, 6'd11, 4'b1111, 32'h7777_0000, 4'b0001, 1'b1);
    fill(20'h0D00E, 6'd12, 4'b1111, 32'h8888_0000, 4'b0001, 1'b0);

    // Kill in IDLE blocks miss acceptance
    miss_valid_i = 1'b1; kill_i = 1'b1; miss_tag_i = 20'h00077; miss_idx_i = 6'd7;
    tick();
    miss_valid_i = 1'b0; kill_i = 1'b0;
    chk("idle_kill_blocks", busy_o, 512'd0);

    // Memory stalls 10 cycles: request held with a stable address
    miss_valid_i = 1'b1; miss_tag_i = 20'hABCDE; miss_idx_i = 6'd33; way_valid_bits_i = 4'b0000;
    tick();
    miss_valid_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("stall_valid", mem_req_valid_o, 512'd1);
      chk("stall_addr", mem_req_addr_o, {486'd0, 20'hABCDE, 6'd33});
      tick();
    end
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    chk("stall_kill_valid", mem_req_valid_o, 512'd0);

    // Kill on the fifth stalled cycle: request drops the next cycle
    miss_valid_i = 1'b1; miss_tag_i = 20'h13579; miss_idx_i = 6'd44;
    tick();
    miss_valid_i = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      kill_i = (c == 5);
      chk("kill5_valid", mem_req_valid_o, 512'd1);
      tick();
    end
    kill_i = 1'b0;
    chk("kill5_dropped", mem_req_valid_o, 512'd0);
    chk("kill5_idle", busy_o, 512'd0);
    tick();
    chk("kill5_no_wr", wr_en_o, 512'd0);

    // Reset during RECV: outputs clear at once, stray beats ignored
    miss_valid_i = 1'b1; miss_tag_i = 20'h2468A; miss_idx_i = 6'd50; way_valid_bits_i = 4'b1111;
    tick();
    miss_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = beat(32'h9999_0000, 0);
    tick();
    rst_i = 1'b1;
    #1;
    chk("arst_busy", busy_o, 512'd0);
    chk("arst_miss_ready", miss_ready_o, 512'd1);
    chk("arst_wr_way", wr_way_o, 512'd0);
    chk("arst_wr_data", wr_data_o, 512'd0);
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_rsp_data_i = beat(32'hAAAA_0000, k);
      tick();
      chk("stray_no_wr", wr_en_o, 512'd0);
      chk("stray_idle", busy_o, 512'd0);
    end
    mem_rsp_valid_i = 1'b0;

    // Pointer restarts at way 0 after reset
    fill(20'h0F00F, 6'd63, 4'b1111, 32'hBBBB_0000, 4'b0001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
